// File: rtl/accum_pkg.sv
// Shared types and constants for the burst accumulator and its adder datapath.
package accum_pkg;

  localparam int ACC_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } accum_state_t;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit ripple-carry adder; overflow is the carry out of the top bit.
module adder_16bit
  import accum_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             carry_in,
  output logic [ACC_W-1:0] sum,
  output logic             overflow
);

  logic [ACC_W:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < ACC_W; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign overflow = carry[ACC_W];

endmodule

// File: rtl/accum_16bit.sv
// Burst accumulator: sums NUM_SAMPLES handshaken operands through adder_16bit and
// publishes the total with a sticky carry flag, pulsing done for one cycle.
module accum_16bit
  import accum_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ACC_W-1:0]  data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              busy,
  output logic [ACC_W-1:0]  sum_out,
  output logic              overflow_out,
  output logic              done
);

  accum_state_t     state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             hs;
  logic             last;

  adder_16bit u_adder (
    .a        (acc),
    .b        (data_in),
    .carry_in (1'b0),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  assign hs   = data_valid & data_ready;
  assign last = (count == CNT_W'(NUM_SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    data_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        data_ready = 1'b1;
        busy       = 1'b1;
        if (hs && last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: running total, sticky carry, sample count and published result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      ovf          <= 1'b0;
      count        <= '0;
      sum_out      <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        acc   <= '0;
        ovf   <= 1'b0;
        count <= '0;
      end else if (state == ACCUM && hs) begin
        acc   <= add_sum;
        ovf   <= ovf | add_ovf;
        count <= count + CNT_W'(1);
        if (last) begin
          sum_out      <= add_sum;
          overflow_out <= ovf | add_ovf;
        end
      end
    end
  end

endmodule
